// File: rtl/dbg_insn_sequencer_pkg.sv
// Shared RV32 encoding helpers for the debug instruction sequencer:
// opcode/funct3 constants, debug CSR addresses, U/I-type word builders.
package dbg_insn_sequencer_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;

    localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
    localparam logic [11:0] CSR_DSCRATCH1 = 12'h7B3;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_TMP  = 5'd5;

    typedef struct packed {
        logic [19:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } utype_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } itype_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm20);
        utype_t u;
        u.imm    = imm20;
        u.rd     = rd;
        u.opcode = OPC_LUI;
        return u;
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm12);
        itype_t i;
        i.imm    = imm12;
        i.rs1    = rs1;
        i.funct3 = f3;
        i.rd     = rd;
        i.opcode = op;
        return i;
    endfunction

    // ADDI sign-extends its 12-bit immediate, so bit 11 must be pre-added into the LUI part.
    function automatic logic [19:0] split_hi(input logic [31:0] value);
        return value[31:12] + {19'd0, value[11]};
    endfunction

endpackage

// File: rtl/dbg_insn_sequencer_if.sv
// Command channel plus instruction-injection channel of the debug sequencer.
// master = debug host/core side, slave = sequencer.
interface dbg_insn_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_is_csr;
    logic [11:0] cmd_regno;
    logic [31:0] cmd_data;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic        cmd_done;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_write, cmd_is_csr, cmd_regno, cmd_data, insn_ready,
        input  cmd_ready, insn_valid, insn, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_is_csr, cmd_regno, cmd_data, insn_ready,
        output cmd_ready, insn_valid, insn, cmd_done, cmd_err
    );

endinterface

// File: rtl/dbg_insn_sequencer.sv
// Turns one GPR/CSR read or write command into a short stream of RV32 instruction
// words for the core's debug-injection slot, moving data through dscratch0/1.
module dbg_insn_sequencer
    import dbg_insn_sequencer_pkg::*;
#(
    parameter logic [11:0] SCRATCH0_CSR = CSR_DSCRATCH0,
    parameter logic [11:0] SCRATCH1_CSR = CSR_DSCRATCH1,
    parameter logic [4:0]  TMP_REG      = REG_TMP
) (
    input logic                 clk,
    input logic                 rst,
    dbg_insn_sequencer_if.slave bus
);

    seq_state_t  state, state_nxt;
    logic [2:0]  step, step_nxt, last_step;
    logic        lat_write, lat_is_csr;
    logic [11:0] lat_regno;
    logic [31:0] lat_data;
    logic        can_accept, accept, illegal;
    logic [19:0] hi;
    logic [11:0] lo;
    logic [4:0]  gpr;
    logic [31:0] word;

    assign can_accept = (state == ST_IDLE) || (state == ST_DONE);
    assign accept     = bus.cmd_valid && can_accept;
    assign illegal    = !bus.cmd_is_csr && (bus.cmd_regno[11:5] != 7'd0);

    assign bus.cmd_ready  = can_accept;
    assign bus.insn_valid = (state == ST_EMIT);
    assign bus.insn       = (state == ST_EMIT) ? word : 32'd0;
    assign bus.cmd_done   = (state == ST_DONE);
    assign bus.cmd_err    = (state == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            step  <= 3'd0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Command payload is plain data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write  <= bus.cmd_write;
            lat_is_csr <= bus.cmd_is_csr;
            lat_regno  <= bus.cmd_regno;
            lat_data   <= bus.cmd_data;
        end
    end

    assign hi  = split_hi(lat_data);
    assign lo  = lat_data[11:0];
    assign gpr = lat_regno[4:0];

    always_comb begin
        last_step = 3'd0;
        case ({lat_is_csr, lat_write})
            2'b00:   last_step = 3'd0;
            2'b01:   last_step = 3'd1;
            2'b10:   last_step = 3'd3;
            default: last_step = 3'd4;
        endcase
    end

    always_comb begin
        word = 32'd0;
        case ({lat_is_csr, lat_write})
            2'b01: begin
                if (step == 3'd0) word = enc_u(gpr, hi);
                else              word = enc_i(OPC_OP_IMM, F3_ADDI, gpr, gpr, lo);
            end
            2'b00: word = enc_i(OPC_SYSTEM, F3_CSRRW, REG_ZERO, gpr, SCRATCH0_CSR);
            2'b11: begin
                case (step)
                    3'd0:    word = enc_i(OPC_SYSTEM, F3_CSRRW, REG_ZERO, TMP_REG, SCRATCH1_CSR);
                    3'd1:    word = enc_u(TMP_REG, hi);
                    3'd2:    word = enc_i(OPC_OP_IMM, F3_ADDI, TMP_REG, TMP_REG, lo);
                    3'd3:    word = enc_i(OPC_SYSTEM, F3_CSRRW, REG_ZERO, TMP_REG, lat_regno);
                    default: word = enc_i(OPC_SYSTEM, F3_CSRRS, TMP_REG, REG_ZERO, SCRATCH1_CSR);
                endcase
            end
            default: begin
                case (step)
                    3'd0:    word = enc_i(OPC_SYSTEM, F3_CSRRW, REG_ZERO, TMP_REG, SCRATCH1_CSR);
                    3'd1:    word = enc_i(OPC_SYSTEM, F3_CSRRS, TMP_REG, REG_ZERO, lat_regno);
                    3'd2:    word = enc_i(OPC_SYSTEM, F3_CSRRW, REG_ZERO, TMP_REG, SCRATCH0_CSR);
                    default: word = enc_i(OPC_SYSTEM, F3_CSRRS, TMP_REG, REG_ZERO, SCRATCH1_CSR);
                endcase
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    state_nxt = illegal ? ST_ERR : ST_EMIT;
                    step_nxt  = 3'd0;
                end
            end
            ST_EMIT: begin
                if (bus.insn_ready) begin
                    if (step == last_step) begin
                        state_nxt = ST_DONE;
                        step_nxt  = 3'd0;
                    end else begin
                        step_nxt = step + 3'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
